// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Stall/flush/forward controller for the 5-stage RISC-V pipeline,
//               with a RUN/MEM_WAIT/FAULT data-memory wait sequencer and
//               watchdog. Define HAZARD_PERF_EN to build the perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int         MEM_TIMEOUT = 255,
  parameter logic [1:0] LOAD_WB_SEL = 2'b01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_D,
  input  logic [4:0]  rs2_D,
  input  logic [4:0]  rs1_E,
  input  logic [4:0]  rs2_E,
  input  logic [4:0]  rd_E,
  input  logic [4:0]  rd_M,
  input  logic [4:0]  rd_W,
  input  logic [1:0]  write_back_E,
  input  logic        write_enable_RF_M,
  input  logic        write_enable_RF_W,
  input  logic        pc_src_E,
  input  logic        dmem_req_M,
  input  logic        dmem_ready,
  output logic [1:0]  forward_a_E,
  output logic [1:0]  forward_b_E,
  output logic        stall_F,
  output logic        stall_D,
  output logic        stall_E,
  output logic        stall_M,
  output logic        flush_D,
  output logic        flush_E,
  output logic        flush_W,
  output logic        mem_fault,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  localparam int c_WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [c_WAIT_W-1:0] c_TIMEOUT    = c_WAIT_W'(MEM_TIMEOUT);
  localparam logic                c_TIMEOUT_EN = (MEM_TIMEOUT != 0);

  localparam logic [1:0] c_ST_RUN      = 2'd0;
  localparam logic [1:0] c_ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] c_ST_FAULT    = 2'd2;

  logic [1:0]          r_state;
  logic [c_WAIT_W-1:0] r_wait_cnt;
  logic                r_mem_fault;

  logic w_lu;
  logic w_mem_stall;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       we_m,
    input logic [4:0] rd_m,
    input logic       we_w,
    input logic [4:0] rd_w
  );
    if (we_m && (rd_m != 5'd0) && (rd_m == rs))
      return 2'b10;
    else if (we_w && (rd_w != 5'd0) && (rd_w == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign w_lu = (write_back_E == LOAD_WB_SEL) && (rd_E != 5'd0) &&
                ((rd_E == rs1_D) || (rd_E == rs2_D));

  assign w_mem_stall = ((r_state == c_ST_RUN)      && dmem_req_M && !dmem_ready) ||
                       ((r_state == c_ST_MEM_WAIT) && !dmem_ready) ||
                       (r_state == c_ST_FAULT);

  always_comb begin
    forward_a_E = 2'b00;
    forward_b_E = 2'b00;
    stall_F     = 1'b0;
    stall_D     = 1'b0;
    stall_E     = 1'b0;
    stall_M     = 1'b0;
    flush_D     = 1'b0;
    flush_E     = 1'b0;
    flush_W     = 1'b0;
    if (!rst_n) begin
      flush_D = 1'b1;
      flush_E = 1'b1;
      flush_W = 1'b1;
    end else begin
      forward_a_E = fwd_sel(rs1_E, write_enable_RF_M, rd_M, write_enable_RF_W, rd_W);
      forward_b_E = fwd_sel(rs2_E, write_enable_RF_M, rd_M, write_enable_RF_W, rd_W);
      if (w_mem_stall) begin
        // Whole pipe frozen; W gets a bubble so the held M op is not retired twice
        stall_F = 1'b1;
        stall_D = 1'b1;
        stall_E = 1'b1;
        stall_M = 1'b1;
        flush_W = 1'b1;
      end else begin
        // A taken branch squashes the load-use victim, so no need to hold F/D
        flush_D = pc_src_E;
        flush_E = pc_src_E | w_lu;
        stall_F = w_lu & ~pc_src_E;
        stall_D = w_lu & ~pc_src_E;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= c_ST_RUN;
      r_wait_cnt  <= '0;
      r_mem_fault <= 1'b0;
    end else begin
      case (r_state)
        c_ST_RUN: begin
          if (dmem_req_M && !dmem_ready) begin
            r_state    <= c_ST_MEM_WAIT;
            r_wait_cnt <= c_WAIT_W'(1);
          end
        end
        c_ST_MEM_WAIT: begin
          if (dmem_ready) begin
            r_state    <= c_ST_RUN;
            r_wait_cnt <= '0;
          end else if (c_TIMEOUT_EN && (r_wait_cnt == c_TIMEOUT)) begin
            r_state     <= c_ST_FAULT;
            r_mem_fault <= 1'b1;
          end else if (r_wait_cnt != '1) begin
            r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
          end
        end
        c_ST_FAULT: begin
          r_mem_fault <= 1'b1;
        end
        default: begin
          r_state <= c_ST_RUN;
        end
      endcase
    end
  end

  assign mem_fault = r_mem_fault;

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_count;

  // Reset-forced flushes never reach the increment branch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cycles <= 32'd0;
      r_flush_count  <= 32'd0;
    end else begin
      if (stall_F)
        r_stall_cycles <= r_stall_cycles + 32'd1;
      if (flush_E)
        r_flush_count <= r_flush_count + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Directed self-checking bench for pipeline_hazard_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic [1:0]  write_back_E;
  logic        write_enable_RF_M, write_enable_RF_W;
  logic        pc_src_E, dmem_req_M, dmem_ready;
  logic [1:0]  forward_a_E, forward_b_E;
  logic        stall_F, stall_D, stall_E, stall_M;
  logic        flush_D, flush_E, flush_W;
  logic        mem_fault;
  logic [31:0] stall_cycles, flush_count;

  int tests_run = 0;
  int tests_failed = 0;

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT (4),
    .LOAD_WB_SEL (2'b01)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rs1_D             (rs1_D),
    .rs2_D             (rs2_D),
    .rs1_E             (rs1_E),
    .rs2_E             (rs2_E),
    .rd_E              (rd_E),
    .rd_M              (rd_M),
    .rd_W              (rd_W),
    .write_back_E      (write_back_E),
    .write_enable_RF_M (write_enable_RF_M),
    .write_enable_RF_W (write_enable_RF_W),
    .pc_src_E          (pc_src_E),
    .dmem_req_M        (dmem_req_M),
    .dmem_ready        (dmem_ready),
    .forward_a_E       (forward_a_E),
    .forward_b_E       (forward_b_E),
    .stall_F           (stall_F),
    .stall_D           (stall_D),
    .stall_E           (stall_E),
    .stall_M           (stall_M),
    .flush_D           (flush_D),
    .flush_E           (flush_E),
    .flush_W           (flush_W),
    .mem_fault         (mem_fault),
    .stall_cycles      (stall_cycles),
    .flush_count       (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and step 1 ns past it before touching inputs
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stall vector {F,D,E,M}, flush vector {D,E,W}
  task automatic check_ctl(input string tag, input logic [3:0] st, input logic [2:0] fl);
    #1;
    check({tag, "_stall"}, {28'd0, stall_F, stall_D, stall_E, stall_M}, {28'd0, st});
    check({tag, "_flush"}, {29'd0, flush_D, flush_E, flush_W}, {29'd0, fl});
  endtask

  initial begin
    rst_n = 1'b0;
    {rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W} = '0;
    write_back_E = 2'b00;
    write_enable_RF_M = 1'b0;
    write_enable_RF_W = 1'b0;
    pc_src_E = 1'b0;
    dmem_req_M = 1'b0;
    dmem_ready = 1'b0;

    // Reset state
    tick();
    tick();
    check_ctl("reset", 4'b0000, 3'b111);
    check("reset_fwd", {30'd0, forward_a_E}, 32'd0);
    check("reset_fault", {31'd0, mem_fault}, 32'd0);
    check("reset_stall_cnt", stall_cycles, 32'd0);
    check("reset_flush_cnt", flush_count, 32'd0);

    rst_n = 1'b1;
    check_ctl("idle", 4'b0000, 3'b000);

    // Forwarding, all inside one cycle
    rd_M = 5'd5; write_enable_RF_M = 1'b1;
    rd_W = 5'd5; write_enable_RF_W = 1'b1;
    rs1_E = 5'd5; rs2_E = 5'd0;
    #1;
    check("fwd_a_m_prio", {30'd0, forward_a_E}, 32'd2);
    check("fwd_b_x0", {30'd0, forward_b_E}, 32'd0);
    write_enable_RF_M = 1'b0;
    rs2_E = 5'd5;
    #1;
    check("fwd_a_w", {30'd0, forward_a_E}, 32'd1);
    check("fwd_b_w", {30'd0, forward_b_E}, 32'd1);
    rd_W = 5'd0;
    #1;
    check("fwd_a_rdw0", {30'd0, forward_a_E}, 32'd0);
    write_enable_RF_M = 1'b1; rd_M = 5'd9; rs2_E = 5'd9;
    #1;
    check("fwd_b_m", {30'd0, forward_b_E}, 32'd2);
    {rd_M, rd_W, rs1_E, rs2_E} = '0;
    write_enable_RF_M = 1'b0; write_enable_RF_W = 1'b0;

    // Branch alone, branch with load-use, load-use with rd_E = 0
    pc_src_E = 1'b1;
    check_ctl("branch", 4'b0000, 3'b110);
    write_back_E = 2'b01; rd_E = 5'd7; rs2_D = 5'd7;
    check_ctl("branch_lu", 4'b0000, 3'b110);
    pc_src_E = 1'b0;
    rd_E = 5'd0;
    check_ctl("lu_rd0", 4'b0000, 3'b000);
    write_back_E = 2'b10; rd_E = 5'd7;
    check_ctl("non_load", 4'b0000, 3'b000);

    // Load-use event 1 (rs2 match), held across one edge
    write_back_E = 2'b01;
    check_ctl("lu1", 4'b1100, 3'b010);
    tick();
    write_back_E = 2'b00; rd_E = 5'd0; rs2_D = 5'd0;
    check_ctl("lu1_done", 4'b0000, 3'b000);
    tick();

    // Load-use event 2 (rs1 match)
    write_back_E = 2'b01; rd_E = 5'd12; rs1_D = 5'd12;
    check_ctl("lu2", 4'b1100, 3'b010);
    tick();
    write_back_E = 2'b00; rd_E = 5'd0; rs1_D = 5'd0;

    // Three-cycle memory wait, then ready
    dmem_req_M = 1'b1; dmem_ready = 1'b0;
    check_ctl("mw_c1", 4'b1111, 3'b001);
    tick();
    pc_src_E = 1'b1; write_back_E = 2'b01; rd_E = 5'd3; rs1_D = 5'd3;
    check_ctl("mw_c2_masked", 4'b1111, 3'b001);
    tick();
    pc_src_E = 1'b0; write_back_E = 2'b00; rd_E = 5'd0; rs1_D = 5'd0;
    check_ctl("mw_c3", 4'b1111, 3'b001);
    tick();
    dmem_ready = 1'b1;
    check_ctl("mw_ready", 4'b0000, 3'b000);
    tick();
    dmem_req_M = 1'b0; dmem_ready = 1'b0;
    check_ctl("mw_back_run", 4'b0000, 3'b000);

`ifdef HAZARD_PERF_EN
    check("perf_stall_cycles", stall_cycles, 32'd5);
    check("perf_flush_count", flush_count, 32'd2);
`else
    check("perf_stall_tied", stall_cycles, 32'd0);
    check("perf_flush_tied", flush_count, 32'd0);
`endif

    // Same-cycle req and ready never stalls
    dmem_req_M = 1'b1; dmem_ready = 1'b1;
    check_ctl("req_ready", 4'b0000, 3'b000);
    tick();
    dmem_req_M = 1'b0; dmem_ready = 1'b0;
    check_ctl("req_ready_after", 4'b0000, 3'b000);

    // Timeout with MEM_TIMEOUT = 4: fault after the fifth stalled cycle
    dmem_req_M = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      check_ctl($sformatf("to_c%0d", i), 4'b1111, 3'b001);
      check($sformatf("to_nofault_c%0d", i), {31'd0, mem_fault}, 32'd0);
      tick();
    end
    check("to_fault", {31'd0, mem_fault}, 32'd1);
    dmem_req_M = 1'b0;
    dmem_ready = 1'b1;
    check_ctl("fault_held", 4'b1111, 3'b001);
    tick();
    tick();
    check("fault_sticky", {31'd0, mem_fault}, 32'd1);
    check_ctl("fault_still", 4'b1111, 3'b001);
    dmem_ready = 1'b0;

    // One-cycle reset clears the fault
    rst_n = 1'b0;
    check_ctl("fault_rst", 4'b0000, 3'b111);
    tick();
    rst_n = 1'b1;
    check("post_rst_fault", {31'd0, mem_fault}, 32'd0);
    check_ctl("post_rst", 4'b0000, 3'b000);
    check("post_rst_stall_cnt", stall_cycles, 32'd0);

    // Reset mid-MEM_WAIT returns to RUN
    dmem_req_M = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    dmem_req_M = 1'b0;
    check_ctl("rst_mid_wait", 4'b0000, 3'b000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall, flush and forward controller for the 5-stage RISC-V pipeline (F/D/E/M/W).
- Drives the enable and clear inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and the E-stage operand-forwarding muxes.
- Sequences multi-cycle data-memory accesses with a RUN/MEM_WAIT/FAULT state machine and a timeout watchdog.

Parameters:
- MEM_TIMEOUT, 255: maximum cycles spent in MEM_WAIT before a fault is declared; 0 disables the timeout.
- LOAD_WB_SEL, 2'b01: write_back_E encoding that identifies a load.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- rs1_D, rs2_D  in  5  source registers in D
- rs1_E, rs2_E  in  5  source registers in E
- rd_E, rd_M, rd_W  in  5  destination registers in E/M/W
- write_back_E  in  2  write-back select in E
- write_enable_RF_M, write_enable_RF_W  in  1  register-file write enables in M/W
- pc_src_E  in  1  branch/jump taken in E
- dmem_req_M  in  1  M-stage instruction accesses data memory
- dmem_ready  in  1  data memory completes the access this cycle
- forward_a_E, forward_b_E  out  2  00 = register file, 10 = alu_rsl_M, 01 = W result
- stall_F, stall_D, stall_E, stall_M  out  1  hold the stage register
- flush_D, flush_E, flush_W  out  1  insert a bubble into the stage register
- mem_fault  out  1  sticky timeout flag
- stall_cycles  out  32  performance counter
- flush_count  out  32  performance counter

Behaviour:
- Reset: rst_n is synchronous, active-low, on clk. Clock is clk.
  - State = RUN, wait_cnt = 0, mem_fault = 0, counters = 0.
  - While rst_n = 0: flush_D, flush_E and flush_W are forced to 1; all stalls are 0; forwards are 00.
- Forwarding (combinational, zero latency), shown for forward_a_E with rs1_E:
  - 10 if write_enable_RF_M && rd_M != 0 && rd_M == rs1_E.
  - Otherwise 01 if write_enable_RF_W && rd_W != 0 && rd_W == rs1_E.
  - Otherwise 00.
  - M has priority over W. forward_b_E is identical using rs2_E.
- Load-use hazard:
  - lu = (write_back_E == LOAD_WB_SEL) && rd_E != 0 && (rd_E == rs1_D || rd_E == rs2_D).
  - Effect: stall_F = stall_D = 1 and flush_E = 1, for one cycle per occurrence.
- Control hazard: pc_src_E = 1 gives flush_D = flush_E = 1. If lu and pc_src_E are both active, the flushes take effect and stall_F/stall_D are dropped.
- Memory stall, mem_stall = 1 when any of:
  - state == RUN && dmem_req_M && !dmem_ready,
  - state == MEM_WAIT && !dmem_ready,
  - state == FAULT.
- When mem_stall = 1:
  - stall_F = stall_D = stall_E = stall_M = 1 and flush_W = 1.
  - flush_D and flush_E are suppressed (0), and lu/branch effects are masked.
- FSM (registered):
  - RUN: dmem_req_M && !dmem_ready leads to MEM_WAIT with wait_cnt = 1. A same-cycle req && ready stays in RUN with no stall.
  - MEM_WAIT, dmem_ready: go to RUN, wait_cnt = 0. Stalls deassert in this same cycle.
  - MEM_WAIT, !dmem_ready, MEM_TIMEOUT != 0 and wait_cnt == MEM_TIMEOUT: go to FAULT, mem_fault = 1.
  - MEM_WAIT, otherwise: wait_cnt++. The counter saturates and never wraps.
  - If dmem_ready arrives in the same cycle as the timeout condition, ready wins.
  - FAULT: held until reset; mem_fault stays 1.
- wait_cnt width is clog2(MEM_TIMEOUT+1), minimum 1.
- Reset asserted mid-MEM_WAIT returns the FSM to RUN on the next edge.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined:
  - stall_cycles increments on each cycle with stall_F = 1.
  - flush_count increments on each cycle with flush_E = 1 (excluding reset-forced flushes).
  - Both are 32-bit and wrap from 0xFFFFFFFF to 0.
- Undefined: both outputs are tied to 0 and no counter flops are present.

Test Plan:
- Forwarding: rd_M = 5, write_enable_RF_M = 1, rd_W = 5, write_enable_RF_W = 1, rs1_E = 5, rs2_E = 0 -> forward_a_E = 10, forward_b_E = 00. With write_enable_RF_M = 0 -> forward_a_E = 01.
- Load-use: write_back_E = 01, rd_E = 7, rs2_D = 7 -> one cycle of stall_F = stall_D = flush_E = 1. With rd_E = 0 -> no stall.
- Branch: pc_src_E = 1 -> flush_D = flush_E = 1 and stall_F = 0, including when lu is also active.
- Memory wait: dmem_req_M = 1 with dmem_ready low for 3 cycles, then high -> stall_F/D/E/M = 1 and flush_W = 1 for 3 cycles, state returns to RUN, stalls = 0 in the ready cycle.
- Timeout: MEM_TIMEOUT = 4, ready never asserted -> mem_fault = 1 after the 5th stall cycle, stall persists until rst_n = 0 for 1 cycle, after which all outputs reset.
- HAZARD_PERF_EN: 2 load-use events plus a 3-cycle memory wait -> stall_cycles = 5, flush_count = 2.
